// File: rtl/spu_axi4_read_responder.sv
// AXI4 read-channel subordinate serving bursts from a preloadable word memory, one burst at a time.
// Define SPU_AXI4_RESP_CHECK_EN to answer out-of-range, wrong-size or WRAP/reserved bursts with SLVERR.
module spu_axi4_read_responder #(
    parameter int AXI4_ID_BITS   = 6,
    parameter int AXI4_ADDR_BITS = 49,
    parameter int AXI4_DATA_BITS = 512,
    parameter int MEM_ADDR_BITS  = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cke,
    input  logic [AXI4_ID_BITS-1:0]   s_axi4_arid,
    input  logic [AXI4_ADDR_BITS-1:0] s_axi4_araddr,
    input  logic [7:0]                s_axi4_arlen,
    input  logic [2:0]                s_axi4_arsize,
    input  logic [1:0]                s_axi4_arburst,
    input  logic                      s_axi4_arvalid,
    output logic                      s_axi4_arready,
    output logic [AXI4_ID_BITS-1:0]   s_axi4_rid,
    output logic [AXI4_DATA_BITS-1:0] s_axi4_rdata,
    output logic [1:0]                s_axi4_rresp,
    output logic                      s_axi4_rlast,
    output logic                      s_axi4_rvalid,
    input  logic                      s_axi4_rready,
    input  logic                      mem_wr_en,
    input  logic [MEM_ADDR_BITS-1:0]  mem_wr_addr,
    input  logic [AXI4_DATA_BITS-1:0] mem_wr_data
);

    localparam int BYTE_BITS = $clog2(AXI4_DATA_BITS / 8);
    localparam int WORD_LSB  = BYTE_BITS;
    localparam int WORD_MSB  = BYTE_BITS + MEM_ADDR_BITS - 1;
    localparam int MEM_DEPTH = 1 << MEM_ADDR_BITS;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_SEND  = 2'd2;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [1:0]                r_state;
    logic [AXI4_ID_BITS-1:0]   r_id;
    logic [7:0]                r_len;
    logic [1:0]                r_burst;
    logic [MEM_ADDR_BITS-1:0]  r_addr;
    logic [7:0]                r_beat;
    logic                      r_err;
    logic                      r_rvalid;
    logic                      r_rlast;
    logic [AXI4_ID_BITS-1:0]   r_rid;
    logic [AXI4_DATA_BITS-1:0] r_rdata;
    logic [1:0]                r_rresp;

    logic [AXI4_DATA_BITS-1:0] r_mem [0:MEM_DEPTH-1];

    logic                     w_ar_fire;
    logic                     w_r_fire;
    logic                     w_ar_err;
    logic [MEM_ADDR_BITS-1:0] w_addr_next;
    logic                     w_unused_bits;

    assign s_axi4_arready = (r_state == ST_IDLE) && !reset;
    assign w_ar_fire      = s_axi4_arvalid && s_axi4_arready;
    assign w_r_fire       = r_rvalid && s_axi4_rready;

    // Byte-lane offset (and, without checking, the size and upper address bits) carry no meaning here.
    assign w_unused_bits = ^{s_axi4_araddr, s_axi4_arsize};

`ifdef SPU_AXI4_RESP_CHECK_EN
    logic w_addr_hi_nz;
    generate
        if (AXI4_ADDR_BITS > WORD_MSB + 1) begin : g_addr_hi
            assign w_addr_hi_nz = |s_axi4_araddr[AXI4_ADDR_BITS-1:WORD_MSB+1];
        end else begin : g_no_addr_hi
            assign w_addr_hi_nz = 1'b0;
        end
    endgenerate

    assign w_ar_err = w_addr_hi_nz
                   || (s_axi4_arsize != 3'(BYTE_BITS))
                   || s_axi4_arburst[1];
`else
    assign w_ar_err = 1'b0;
`endif

    // Anything other than FIXED advances the word address, wrapping at the top of memory.
    assign w_addr_next = (r_burst == BURST_FIXED)
                       ? r_addr
                       : r_addr + {{(MEM_ADDR_BITS-1){1'b0}}, 1'b1};

    // Preload port is independent of the FSM and of reset; contents survive reset.
    always_ff @(posedge clk) begin
        if (cke && mem_wr_en) begin
            r_mem[mem_wr_addr] <= mem_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_id     <= '0;
            r_len    <= '0;
            r_burst  <= '0;
            r_addr   <= '0;
            r_beat   <= '0;
            r_err    <= 1'b0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (cke) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ar_fire) begin
                        r_id    <= s_axi4_arid;
                        r_len   <= s_axi4_arlen;
                        r_burst <= s_axi4_arburst;
                        r_addr  <= s_axi4_araddr[WORD_MSB:WORD_LSB];
                        r_err   <= w_ar_err;
                        r_beat  <= '0;
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Registered read port; a write to the same word this cycle is not visible yet.
                    r_rdata  <= r_err ? '0 : r_mem[r_addr];
                    r_rid    <= r_id;
                    r_rresp  <= r_err ? RESP_SLVERR : RESP_OKAY;
                    r_rlast  <= (r_beat == r_len);
                    r_rvalid <= 1'b1;
                    r_state  <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_r_fire) begin
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                        if (r_rlast) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_beat  <= r_beat + 8'd1;
                            r_addr  <= w_addr_next;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_axi4_rvalid = r_rvalid;
    assign s_axi4_rlast  = r_rlast;
    assign s_axi4_rid    = r_rid;
    assign s_axi4_rdata  = r_rdata;
    assign s_axi4_rresp  = r_rresp;

endmodule

// File: tb/tb_spu_axi4_read_responder.sv
// Scoreboard bench for spu_axi4_read_responder: stimulus queues expected beats, a negedge monitor checks them.
module tb_spu_axi4_read_responder;

    localparam int IDW = 6;
    localparam int AW  = 49;
    localparam int DW  = 512;
    localparam int MW  = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          cke;
    logic [IDW-1:0] arid;
    logic [AW-1:0]  araddr;
    logic [7:0]     arlen;
    logic [2:0]     arsize;
    logic [1:0]     arburst;
    logic           arvalid;
    logic           arready;
    logic [IDW-1:0] rid;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rlast;
    logic           rvalid;
    logic           rready;
    logic           mem_wr_en;
    logic [MW-1:0]  mem_wr_addr;
    logic [DW-1:0]  mem_wr_data;

    spu_axi4_read_responder #(
        .AXI4_ID_BITS  (IDW),
        .AXI4_ADDR_BITS(AW),
        .AXI4_DATA_BITS(DW),
        .MEM_ADDR_BITS (MW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cke           (cke),
        .s_axi4_arid   (arid),
        .s_axi4_araddr (araddr),
        .s_axi4_arlen  (arlen),
        .s_axi4_arsize (arsize),
        .s_axi4_arburst(arburst),
        .s_axi4_arvalid(arvalid),
        .s_axi4_arready(arready),
        .s_axi4_rid    (rid),
        .s_axi4_rdata  (rdata),
        .s_axi4_rresp  (rresp),
        .s_axi4_rlast  (rlast),
        .s_axi4_rvalid (rvalid),
        .s_axi4_rready (rready),
        .mem_wr_en     (mem_wr_en),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic [1:0]     resp;
        logic           last;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] model_mem [0:(1<<MW)-1];
    int            total = 0;
    int            bad   = 0;

    beat_t snap;
    logic  snap_v = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act[63:0], exp[63:0]);
        end
    endtask

    function automatic logic [DW-1:0] word_val(input logic [31:0] v);
        logic [DW-1:0] w;
        w = '0;
        w[31:0] = v;
        return w;
    endfunction

    task automatic preload(input logic [MW-1:0] a, input logic [DW-1:0] d);
        mem_wr_en   = 1'b1;
        mem_wr_addr = a;
        mem_wr_data = d;
        tick();
        mem_wr_en   = 1'b0;
        model_mem[a] = d;
    endtask

    // Queue the expected beats, then perform the AR handshake.
    task automatic send_ar(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        logic          err;
        logic [MW-1:0] wa;
        beat_t         b;
        int            n;
        err = 1'b0;
`ifdef SPU_AXI4_RESP_CHECK_EN
        err = (addr[AW-1:16] != '0) || (size != 3'd6) || burst[1];
`endif
        wa = addr[15:6];
        for (int i = 0; i <= int'(len); i++) begin
            b.id   = id;
            b.data = err ? '0 : model_mem[wa];
            b.resp = err ? 2'b10 : 2'b00;
            b.last = (i == int'(len));
            exp_q.push_back(b);
            if (burst != 2'b00) wa = wa + 10'd1;
        end
        arid    = id;
        araddr  = addr;
        arlen   = len;
        arsize  = size;
        arburst = burst;
        arvalid = 1'b1;
        n = 0;
        while (!arready && n < 50) begin
            tick();
            n++;
        end
        if (!arready) begin
            total++;
            bad++;
            $display("FAIL ar_accept: arready stuck low after %0d cycles", n);
        end
        tick();
        arvalid = 1'b0;
    endtask

    task automatic wait_rvalid(input string nm);
        int n;
        n = 0;
        while (!rvalid && n < 50) begin
            tick();
            n++;
        end
        if (!rvalid) begin
            total++;
            bad++;
            $display("FAIL %s: rvalid not seen within %0d cycles", nm, n);
        end
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rvalid) && n < 300) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0 || rvalid) begin
            total++;
            bad++;
            $display("FAIL %s: %0d beats still pending, rvalid=%0b", nm, exp_q.size(), rvalid);
            exp_q.delete();
        end
    endtask

    // Monitor: pops on each accepted beat and checks stability across stalled cycles.
    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        if (reset) begin
            snap_v = 1'b0;
        end else if (rvalid) begin
            cur = {rid, rdata, rresp, rlast};
            if (snap_v) begin
                total++;
                if (cur !== snap) begin
                    bad++;
                    $display("FAIL hold_stable: got id=%0d data=%h resp=%0d last=%0b expected id=%0d data=%h resp=%0d last=%0b",
                             cur.id, cur.data[63:0], cur.resp, cur.last,
                             snap.id, snap.data[63:0], snap.resp, snap.last);
                end
            end
            if (cke && rready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: got id=%0d data=%h required no beat", rid, rdata[63:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        bad++;
                        $display("FAIL beat: got id=%0d data=%h resp=%0d last=%0b expected id=%0d data=%h resp=%0d last=%0b",
                                 cur.id, cur.data[63:0], cur.resp, cur.last,
                                 e.id, e.data[63:0], e.resp, e.last);
                    end else begin
                        $display("beat ok: id=%0d data=%h resp=%0d last=%0b", cur.id, cur.data[63:0], cur.resp, cur.last);
                    end
                end
                snap_v = 1'b0;
            end else begin
                snap   = cur;
                snap_v = 1'b1;
            end
        end else if (snap_v) begin
            total++;
            bad++;
            $display("FAIL rvalid_drop: got rvalid=0 required 1 while beat unaccepted");
            snap_v = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        for (int i = 0; i < (1<<MW); i++) model_mem[i] = '0;
        reset       = 1'b1;
        cke         = 1'b1;
        arid        = '0;
        araddr      = '0;
        arlen       = '0;
        arsize      = '0;
        arburst     = '0;
        arvalid     = 1'b0;
        rready      = 1'b1;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_arready", DW'(arready), DW'(0));
        chk("rst_rvalid",  DW'(rvalid),  DW'(0));
        chk("rst_rlast",   DW'(rlast),   DW'(0));
        chk("rst_rid",     DW'(rid),     DW'(0));
        chk("rst_rresp",   DW'(rresp),   DW'(0));
        chk("rst_rdata",   rdata,        '0);
        reset = 1'b0;
        #1;
        chk("rel_arready", DW'(arready), DW'(1));

        preload(10'd0, word_val(32'hA0));
        preload(10'd1, word_val(32'hA1));
        preload(10'd2, word_val(32'hA2));
        preload(10'd3, word_val(32'hA3));
        preload(10'd7, word_val(32'h77));
        preload(10'd1023, word_val(32'hBEEF));

        // INCR len 3 from word 0, plus first-beat latency
        send_ar(6'd5, '0, 8'd3, 3'd6, 2'b01);
        chk("lat_fetch", DW'(rvalid), DW'(0));
        tick();
        chk("lat_first", DW'(rvalid), DW'(1));
        wait_drain("incr4");

        // INCR wrap from top word
        a = AW'(1023) << 6;
        send_ar(6'd2, a, 8'd1, 3'd6, 2'b01);
        wait_drain("wrap");

        // FIXED len 2 at word 7 with rready 1,0,1
        a = AW'(7) << 6;
        send_ar(6'd3, a, 8'd2, 3'd6, 2'b00);
        wait_rvalid("fixed_b1");
        tick();
        rready = 1'b0;
        tick(); tick(); tick(); tick();
        chk("fixed_stall_valid", DW'(rvalid), DW'(1));
        rready = 1'b1;
        wait_drain("fixed");

        // Clock enable low for 3 cycles mid-burst
        send_ar(6'd4, '0, 8'd3, 3'd6, 2'b01);
        wait_rvalid("cke_b1");
        cke = 1'b0;
        tick(); tick(); tick();
        chk("cke_frozen_valid", DW'(rvalid), DW'(1));
        cke = 1'b1;
        wait_drain("cke");

        // Reset during beat 2 of a len-7 burst
        send_ar(6'd6, '0, 8'd7, 3'd6, 2'b01);
        wait_rvalid("rstb_b1");
        tick();
        rready = 1'b0;
        wait_rvalid("rstb_b2");
        reset = 1'b1;
        exp_q.delete();
        tick();
        chk("midrst_rvalid",  DW'(rvalid),  DW'(0));
        chk("midrst_arready", DW'(arready), DW'(0));
        reset = 1'b0;
        #1;
        chk("postrst_arready", DW'(arready), DW'(1));
        rready = 1'b1;
        a = AW'(7) << 6;
        send_ar(6'd7, a, 8'd0, 3'd6, 2'b01);
        wait_drain("postrst");

        // Address bit above memory range
        a = (AW'(1) << 16) | (AW'(2) << 6);
        send_ar(6'd1, a, 8'd1, 3'd6, 2'b01);
        wait_drain("hiaddr");

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spu_axi4_read_responder.md
SPU_AXI4_READ_RESPONDER -- requirements
Module: spu_axi4_read_responder

Interface
REQ-001 SHALL use one clock, clk; reset SHALL be synchronous and active-high, named reset; cke is the clock enable.
REQ-002 Parameter AXI4_ID_BITS, default 6, SHALL set the ID width.
REQ-003 Parameter AXI4_ADDR_BITS, default 49, SHALL set the byte address width.
REQ-004 Parameter AXI4_DATA_BITS, default 512, SHALL set the data width; BYTE_BITS = log2(AXI4_DATA_BITS/8).
REQ-005 Parameter MEM_ADDR_BITS, default 10, SHALL set the memory depth to 2^MEM_ADDR_BITS words.
REQ-006 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  clock
  reset  in  1  synchronous active-high reset
  cke  in  1  clock enable
  s_axi4_arid  in  AXI4_ID_BITS  read ID
  s_axi4_araddr  in  AXI4_ADDR_BITS  byte address
  s_axi4_arlen  in  8  beats-1
  s_axi4_arsize  in  3  beat size
  s_axi4_arburst  in  2  burst type
  s_axi4_arvalid  in  1  AR valid
  s_axi4_arready  out  1  AR ready
  s_axi4_rid  out  AXI4_ID_BITS  returned ID
  s_axi4_rdata  out  AXI4_DATA_BITS  read data
  s_axi4_rresp  out  2  response
  s_axi4_rlast  out  1  last beat
  s_axi4_rvalid  out  1  R valid
  s_axi4_rready  in  1  R ready
  mem_wr_en  in  1  preload write enable
  mem_wr_addr  in  MEM_ADDR_BITS  preload word address
  mem_wr_data  in  AXI4_DATA_BITS  preload data

Function
REQ-007 Responder SHALL be the subordinate end of the SPU AXI4 read channel; one burst outstanding at a time.
REQ-008 FSM states IDLE, FETCH, SEND; all state, memory writes and handshakes SHALL advance only on cycles with cke=1.
REQ-009 s_axi4_arready SHALL equal (state==IDLE) && !reset.
REQ-010 IDLE: on arvalid&&arready SHALL capture arid, arlen, arburst, word address araddr[BYTE_BITS+MEM_ADDR_BITS-1:BYTE_BITS], clear beat counter, go FETCH.
REQ-011 FETCH: SHALL read memory at current word address (1-cycle read latency), go SEND with rvalid=1, rdata registered, rid = captured ID.
REQ-012 SEND: rvalid, rdata, rid, rresp, rlast SHALL stay stable until rvalid&&rready.
REQ-013 rlast SHALL be 1 exactly on the beat where beat counter == captured arlen.
REQ-014 On handshake with rlast=1 SHALL go IDLE, rvalid=0; otherwise beat counter+1, address update, go FETCH.
REQ-015 Address update: INCR (2'b01) SHALL add 1 modulo 2^MEM_ADDR_BITS (wrap to 0 at top); FIXED (2'b00) SHALL hold; WRAP/reserved treated as INCR when checking is off.
REQ-016 Throughput SHALL be one beat per 2 cycles with rready held 1; AR-to-first-rvalid latency 2 cycles.
REQ-017 Memory write port SHALL write on mem_wr_en at any state; same-cycle same-address read SHALL return old data (read-first).
REQ-018 arsize SHALL be ignored (full-width beats assumed) when checking is off; rresp SHALL be 2'b00 OKAY.

Reset
REQ-019 Reset SHALL force state IDLE, rvalid=0, rlast=0, rid=0, rdata=0, rresp=0, beat counter 0; arready=0 while reset=1, 1 the cycle after; memory contents SHALL NOT be cleared; a burst in progress SHALL be abandoned.

Configuration
REQ-020 Macro SPU_AXI4_RESP_CHECK_EN defined: bursts with araddr bits above BYTE_BITS+MEM_ADDR_BITS nonzero, arsize != BYTE_BITS, or arburst in {2'b10, 2'b11} SHALL return all arlen+1 beats with rresp=2'b10 SLVERR and rdata=0; undefined: no checks, address truncated, rresp always OKAY.

Verification
REQ-021 Preload words 0..3 = 0xA0..0xA3; AR addr 0x0, len 3, INCR, id 5 -> rdata A0,A1,A2,A3, rid 5, rlast on 4th beat only, rresp 0.
REQ-022 AR addr word 1023, len 1, INCR -> beats word 1023 then word 0 (wrap).
REQ-023 FIXED burst len 2 at word 7 -> three beats all word-7 data; rready toggled 1,0,1 -> data held stable while rready=0.
REQ-024 Reset asserted during beat 2 of len-7 burst -> next cycle rvalid=0, arready=1 after release; new AR accepted and served correctly.
REQ-025 With SPU_AXI4_RESP_CHECK_EN: araddr bit 16 set, len 1 -> two beats, rresp 2'b10, rdata 0, rlast on 2nd; without macro: same AR returns word data with OKAY.
REQ-026 cke=0 for 3 cycles mid-burst with rready=1 -> outputs frozen, no beat consumed, burst resumes on cke=1.
